// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel strobe at half the system clock, h/v position
// counters, and registered sync/visible-area decode aligned to the counters.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  output logic        VGA_HSYNC,
  output logic        VGA_VSYNC,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        displaying,
  output logic        pixel_en,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic        pixel_en_q, pixel_en_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        displaying_q, displaying_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    pixel_en_d    = ~pixel_en_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pixel_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 11'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
    // Decode from the next counter values so the flags land on the same edge as x/y.
    displaying_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
    hsync_d      = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
    vsync_d      = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      pixel_en_q    <= 1'b0;
      h_cnt_q       <= H_LAST;
      v_cnt_q       <= V_LAST;
      displaying_q  <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pixel_en_q    <= pixel_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      displaying_q  <= displaying_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_en    = pixel_en_q;
  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign displaying  = displaying_q;
  assign VGA_HSYNC   = hsync_q;
  assign VGA_VSYNC   = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full horizontal timing, short vertical frame so two frames fit
// in a short run; expectations come from a position-versus-clock-count model.
module tb_vga_timing;

  localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
  localparam int VV = 3, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int LINE = 2 * HT;
  localparam int FRAME = LINE * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs, vs, disp, pe, fs;
  logic [10:0] x, y;
  logic [26:0] obs;

  int n_checks = 0;
  int n_pass = 0;
  int n = 0;

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .CLK50MHZ   (clk),
    .RST        (rst),
    .VGA_HSYNC  (hs),
    .VGA_VSYNC  (vs),
    .x          (x),
    .y          (y),
    .displaying (disp),
    .pixel_en   (pe),
    .frame_start(fs)
  );

  always #5 clk = ~clk;

  assign obs = {hs, vs, x, y, disp, pe, fs};

  // n = clock edges since the last edge that saw reset; inputs change and outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) n = 0;
    else n = n + 1;
    #1;
  endtask

  function automatic logic [2:0] decode(input int h, input int v);
    return {!(h >= HV + HF && h < HV + HF + HSW),
            !(v >= VV + VF && v < VV + VF + VSW),
            (h < HV && v < VV)};
  endfunction

  // Edge 1 after release raises pixel_en, edge 2 enters (0,0); each position then lasts 2 clocks.
  function automatic logic [26:0] model(input int k);
    int h, v, l;
    logic p, f;
    logic [2:0] d;
    if (k < 2) begin
      h = HT - 1; v = VT - 1; p = (k == 1); f = 1'b0;
    end else begin
      l = (k - 2) / 2;
      h = l % HT;
      v = (l / HT) % VT;
      p = (k % 2 == 1);
      f = (k % 2 == 0) && (l % (HT * VT) == 0);
    end
    d = decode(h, v);
    return {d[2], d[1], 11'(h), 11'(v), d[0], p, f};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 11'(HT - 1), 11'(VT - 1), 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state got %h want %h", obs, {1'b1, 1'b1, 11'(HT - 1), 11'(VT - 1), 3'b000});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (pe !== 1'b1 || int'(x) != HT - 1 || fs !== 1'b0)
      $display("FAIL release_clk1 got pe=%b x=%0d fs=%b want pe=1 x=%0d fs=0", pe, x, fs, HT - 1);
    else n_pass++;
    tick();
    n_checks++;
    if (int'(x) != 0 || int'(y) != 0 || disp !== 1'b1 || fs !== 1'b1 || pe !== 1'b0)
      $display("FAIL release_clk2 got x=%0d y=%0d disp=%b fs=%b pe=%b want 0 0 1 1 0", x, y, disp, fs, pe);
    else n_pass++;
    tick();
    n_checks++;
    if (int'(x) != 0 || fs !== 1'b0 || pe !== 1'b1)
      $display("FAIL release_clk3 got x=%0d fs=%b pe=%b want 0 0 1", x, fs, pe);
    else n_pass++;
    tick();
    n_checks++;
    if (int'(x) != 1 || pe !== 1'b0)
      $display("FAIL release_clk4 got x=%0d pe=%b want 1 0", x, pe);
    else n_pass++;
  endtask

  task automatic test_line();
    int t, disp_cnt, hs_cnt, hs_fall, first_low;
    logic prev_hs;
    t = 0;
    while (!(int'(x) == 0 && pe == 1'b0) && t < 4 * LINE) begin tick(); t++; end
    n_checks++;
    if (int'(x) != 0 || pe !== 1'b0) $display("FAIL line_start_timeout got x=%0d want 0", x);
    else n_pass++;
    disp_cnt = 0; hs_cnt = 0; hs_fall = -1; first_low = -1; prev_hs = hs;
    for (int i = 0; i < LINE; i++) begin
      n_checks++;
      if (obs !== model(n)) $display("FAIL line_model n=%0d got %h want %h", n, obs, model(n));
      else n_pass++;
      if (disp) disp_cnt++;
      else if (first_low < 0) first_low = i;
      if (!hs) hs_cnt++;
      if (prev_hs && !hs && hs_fall < 0) hs_fall = i;
      prev_hs = hs;
      tick();
    end
    n_checks++;
    if (disp_cnt != 2 * HV || first_low != 2 * HV)
      $display("FAIL line_displaying got high=%0d first_low=%0d want %0d %0d", disp_cnt, first_low, 2 * HV, 2 * HV);
    else n_pass++;
    n_checks++;
    if (hs_cnt != 2 * HSW) $display("FAIL line_hsync_width got %0d want %0d", hs_cnt, 2 * HSW);
    else n_pass++;
    n_checks++;
    if (hs_fall != 2 * (HV + HF)) $display("FAIL line_hsync_fall got %0d want %0d", hs_fall, 2 * (HV + HF));
    else n_pass++;
  endtask

  task automatic test_frame();
    int t, fs_cnt, last_fs, vs_cnt, vs_fall, y_hit, prev_x, prev_y;
    t = 0;
    while (fs !== 1'b1 && t < 2 * FRAME) begin tick(); t++; end
    n_checks++;
    if (fs !== 1'b1) $display("FAIL frame_start_timeout got fs=%b want 1", fs);
    else n_pass++;
    fs_cnt = 0; last_fs = -1; vs_cnt = 0; vs_fall = -1; y_hit = -1; prev_x = -1; prev_y = -1;
    for (int i = 0; i <= 2 * FRAME; i++) begin
      n_checks++;
      if (obs !== model(n)) $display("FAIL frame_model n=%0d got %h want %h", n, obs, model(n));
      else n_pass++;
      n_checks++;
      if ({hs, vs, disp} !== decode(int'(x), int'(y)))
        $display("FAIL consistency x=%0d y=%0d got %b want %b", x, y, {hs, vs, disp}, decode(int'(x), int'(y)));
      else n_pass++;
      n_checks++;
      if (int'(x) > HT - 1 || int'(y) > VT - 1) $display("FAIL range got x=%0d y=%0d", x, y);
      else n_pass++;
      if (fs) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (i - last_fs != FRAME) $display("FAIL frame_period got %0d want %0d", i - last_fs, FRAME);
          else n_pass++;
        end
        last_fs = i;
        fs_cnt++;
      end
      if (i < FRAME) begin
        if (!vs) vs_cnt++;
        if (!vs && vs_fall < 0) vs_fall = i;
        if (int'(y) == VV + VF && y_hit < 0) y_hit = i;
      end
      if (!pe && prev_x == HT - 1 && prev_y == VV - 1) begin
        n_checks++;
        if (int'(x) != 0 || int'(y) != VV || disp !== 1'b0)
          $display("FAIL wrap_visible_end got x=%0d y=%0d disp=%b want 0 %0d 0", x, y, disp, VV);
        else n_pass++;
      end
      if (!pe && prev_x == HT - 1 && prev_y == VT - 1) begin
        n_checks++;
        if (int'(x) != 0 || int'(y) != 0 || disp !== 1'b1 || fs !== 1'b1)
          $display("FAIL wrap_frame got x=%0d y=%0d disp=%b fs=%b want 0 0 1 1", x, y, disp, fs);
        else n_pass++;
      end
      prev_x = int'(x);
      prev_y = int'(y);
      tick();
    end
    n_checks++;
    if (fs_cnt != 3) $display("FAIL frame_start_count got %0d want 3", fs_cnt);
    else n_pass++;
    n_checks++;
    if (vs_cnt != LINE * VSW) $display("FAIL vsync_width got %0d want %0d", vs_cnt, LINE * VSW);
    else n_pass++;
    n_checks++;
    if (vs_fall != y_hit || vs_fall != LINE * (VV + VF))
      $display("FAIL vsync_start got %0d y_hit=%0d want %0d", vs_fall, y_hit, LINE * (VV + VF));
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int t;
    t = 0;
    while (vs !== 1'b0 && t < 2 * FRAME) begin tick(); t++; end
    n_checks++;
    if (vs !== 1'b0) $display("FAIL vsync_wait_timeout got vs=%b want 0", vs);
    else n_pass++;
    repeat ($urandom_range(0, 40)) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== {1'b1, 1'b1, 11'(HT - 1), 11'(VT - 1), 3'b000})
      $display("FAIL vsync_reset got %h want %h", obs, {1'b1, 1'b1, 11'(HT - 1), 11'(VT - 1), 3'b000});
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (obs !== model(n)) $display("FAIL vsync_rerelease n=%0d got %h want %h", n, obs, model(n));
      else n_pass++;
    end
    t = 0;
    while (int'(x) != 700 && t < 2 * LINE) begin tick(); t++; end
    n_checks++;
    if (int'(x) != 700 || hs !== 1'b0) $display("FAIL hsync_wait got x=%0d hs=%b want 700 0", x, hs);
    else n_pass++;
    if ($urandom_range(0, 1) == 1) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (hs !== 1'b1 || int'(x) != HT - 1 || int'(y) != VT - 1 || pe !== 1'b0)
      $display("FAIL hsync_reset got hs=%b x=%0d y=%0d pe=%b want 1 %0d %0d 0", hs, x, y, pe, HT - 1, VT - 1);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (obs !== model(n)) $display("FAIL hsync_rerelease n=%0d got %h want %h", n, obs, model(n));
      else n_pass++;
    end
  endtask

  task automatic test_random_reset();
    int run, hold;
    for (int it = 0; it < 6; it++) begin
      run = int'($urandom_range(1, 1500));
      hold = int'($urandom_range(1, 3));
      for (int i = 0; i < run; i++) begin
        tick();
        n_checks++;
        if (obs !== model(n)) $display("FAIL random_run it=%0d n=%0d got %h want %h", it, n, obs, model(n));
        else n_pass++;
      end
      rst = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        n_checks++;
        if (obs !== model(n)) $display("FAIL random_reset it=%0d got %h want %h", it, obs, model(n));
        else n_pass++;
      end
      rst = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (obs !== model(n)) $display("FAIL random_tail n=%0d got %h want %h", n, obs, model(n));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_random_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have exactly one clock, CLK50MHZ; reset RST is synchronous and active-high.
REQ-002 Parameters (name, default, meaning), one per line:
  H_VISIBLE 640 active pixels/line; H_FRONT 16 front porch; H_SYNC 96 sync width; H_BACK 48 back porch.
  V_VISIBLE 480 active lines; V_FRONT 10 front porch; V_SYNC 2 sync width; V_BACK 33 back porch.
REQ-003 Ports (name, direction, width, meaning), one per line:
  CLK50MHZ  in  1  system clock, 50 MHz
  RST  in  1  synchronous active-high reset
  VGA_HSYNC  out  1  horizontal sync, active-low
  VGA_VSYNC  out  1  vertical sync, active-low
  x  out  11  current horizontal pixel position
  y  out  11  current vertical line position
  displaying  out  1  high when (x,y) is inside the visible area
  pixel_en  out  1  pixel-rate strobe, high every second CLK50MHZ cycle
  frame_start  out  1  one-clock pulse at entry to position (0,0)

Function
REQ-004 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525).
REQ-005 pixel_en SHALL be a register that toggles on every CLK50MHZ edge while RST is low.
REQ-006 Internal counters h_cnt and v_cnt SHALL advance only on an edge where pixel_en is 1; they SHALL hold otherwise.
REQ-007 On advance: h_cnt = H_TOTAL-1 wraps to 0, else h_cnt+1.
REQ-008 v_cnt SHALL increment only when h_cnt wraps: v_cnt = V_TOTAL-1 wraps to 0, else v_cnt+1.
REQ-009 x, y SHALL equal h_cnt, v_cnt, unsigned and zero-extended to 11 bits.
REQ-010 displaying SHALL be 1 iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-011 VGA_HSYNC SHALL be 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
REQ-012 VGA_VSYNC SHALL be 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (default 490..491).
REQ-013 x, y, displaying, VGA_HSYNC and VGA_VSYNC SHALL be registered and SHALL change on the same edge as the counters; they SHALL never disagree about position.
REQ-014 frame_start SHALL be 1 for exactly the one clock after the edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0); it SHALL be 0 on every other clock.
REQ-015 Each position SHALL be held for exactly 2 clocks. A line SHALL last 1600 clocks and a frame 840000 clocks (defaults).
REQ-016 No combinational path SHALL run from any input to any output.

Reset
REQ-017 While RST=1 on an edge, the block SHALL set: pixel_en=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, x=799, y=524, displaying=0, VGA_HSYNC=1, VGA_VSYNC=1, frame_start=0.
REQ-018 After RST falls, the first edge SHALL set pixel_en=1. The second edge SHALL move the counters to (0,0), set displaying=1, and pulse frame_start.
REQ-019 RST asserted mid-frame, including mid sync pulse, SHALL apply REQ-017 on the next edge with no partial-frame completion.

Verification
REQ-020 Reset release: hold RST 3 clocks, then release -> pixel_en 0,1,0,1...; on the 2nd clock after release x=0, y=0, displaying=1, frame_start=1; on the 3rd clock frame_start=0 and x=0; on the 4th clock x=1.
REQ-021 Line timing: run 1 line -> displaying high for 1280 clocks then low for 320; VGA_HSYNC low for exactly 192 clocks, falling 1312 clocks after x becomes 0.
REQ-022 Frame timing: run 2 frames -> frame_start pulses exactly 840000 clocks apart, one clock wide; VGA_VSYNC low for 3200 clocks, starting when y becomes 490; y never exceeds 524 and x never exceeds 799.
REQ-023 Wrap boundary: observe x=799, y=479 -> next advance gives x=0, y=480, displaying=0. Observe x=799, y=524 -> next advance gives x=0, y=0, displaying=1, frame_start=1.
REQ-024 Mid-operation reset: assert RST for 1 clock while x=700 (VGA_HSYNC=0) -> next clock VGA_HSYNC=1, x=799, y=524, pixel_en=0; the REQ-018 sequence then repeats.
REQ-025 Consistency check: on every clock, displaying, VGA_HSYNC and VGA_VSYNC SHALL equal the REQ-010..012 decode of the concurrently output x and y.
